secded_scrubber: RTL and testbench

Background scrub controller for a single-port memory of 13-bit SECDED codewords. Bit 0 is the global parity; bits 12:1 are the Hamming-positioned word.
- Walks every address, reads the word, and checks it through an internal SECDEDdecoder instance.
- Writes back corrected words and reports uncorrectable ones.
- Shares the memory port with a host requester: host has priority, subject to a starvation guard.

---
 rtl/secded_scrubber_if.sv | 25 ++
 rtl/secded_scrubber.sv | 164 ++++++++++++++++
 tb/tb_secded_scrubber.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_scrubber_if.sv
// Shared memory-port bundle between the scrub controller, the host requester and the memory.
// Host handshake: host_req is the request and host_gnt is the grant; an access takes place in every cycle where both are high.
interface secded_scrubber_if #(
    parameter int ADDR_W = 8
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic              host_gnt;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [12:0]       mem_wdata;
    logic [12:0]       mem_rdata;

    modport master (
        input  host_req, host_we, host_addr, mem_rdata,
        output host_gnt, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output host_req, host_we, host_addr, mem_rdata,
        input  host_gnt, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/secded_scrubber.sv
// Background SECDED scrubber: walks the memory, corrects single-bit errors in place,
// reports uncorrectable words, and shares the port with a host under a starvation guard.
module secded_decoder (
    input  logic [12:0] code,
    output logic [12:0] corrected,
    output logic        correctable,
    output logic        uncorrectable
);
    logic [3:0] syn;
    logic       par_err;

    always_comb begin
        syn = 4'd0;
        for (int p = 1; p <= 12; p++) begin
            if (code[p]) syn = syn ^ 4'(p);
        end
        par_err       = ^code;
        // Syndrome 0 with a parity error means bit 0 itself flipped.
        corrected     = code ^ (13'd1 << syn);
        correctable   = par_err && (syn <= 4'd12);
        uncorrectable = (par_err && (syn > 4'd12)) || (!par_err && (syn != 4'd0));
    end
endmodule

module secded_scrubber #(
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int CNT_W        = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    secded_scrubber_if.master       bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err_valid,
    output logic                    err_uncorr,
    output logic [ADDR_W-1:0]       err_addr,
    output logic [CNT_W-1:0]        corr_count,
    output logic [CNT_W-1:0]        uncorr_count,
    output logic [2:0]              state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] scrub_addr;
    logic [SW-1:0]     starve;
    logic [12:0]       corr_word;

    logic [12:0] dec_word;
    logic        dec_corr, dec_uncorr;

    logic contend, forced, scrub_port, hazard;
    logic clear, advance, inc_corr, inc_uncorr, ev, ev_uncorr;

    secded_decoder u_dec (
        .code          (bus.mem_rdata),
        .corrected     (dec_word),
        .correctable   (dec_corr),
        .uncorrectable (dec_uncorr)
    );

    // Arbitration: host wins unless the scrubber has been starved for STARVE_LIMIT cycles.
    always_comb begin
        contend      = (state == ISSUE) || (state == WRITE);
        forced       = contend && (starve == SW'(STARVE_LIMIT));
        bus.host_gnt = bus.host_req && !forced;
        scrub_port   = contend && !bus.host_gnt;
        hazard       = (state == WRITE) && bus.host_gnt && bus.host_we &&
                       (bus.host_addr == scrub_addr);
    end

    always_comb begin
        state_n    = state;
        clear      = 1'b0;
        advance    = 1'b0;
        inc_corr   = 1'b0;
        inc_uncorr = 1'b0;
        ev         = 1'b0;
        ev_uncorr  = 1'b0;
        case (state)
            IDLE:  if (start) begin
                       clear   = 1'b1;
                       state_n = ISSUE;
                   end
            ISSUE: if (scrub_port) state_n = CHECK;
            CHECK: begin
                if (dec_corr) begin
                    ev       = 1'b1;
                    inc_corr = 1'b1;
                    state_n  = WRITE;
                end else if (dec_uncorr) begin
                    ev         = 1'b1;
                    ev_uncorr  = 1'b1;
                    inc_uncorr = 1'b1;
                    advance    = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            WRITE: if (scrub_port || hazard) advance = 1'b1;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (advance) state_n = (scrub_addr == LAST_ADDR) ? DONE : ISSUE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            scrub_addr   <= '0;
            starve       <= '0;
            corr_word    <= '0;
            corr_count   <= '0;
            uncorr_count <= '0;
        end else begin
            state <= state_n;
            if (clear) begin
                scrub_addr   <= '0;
                corr_count   <= '0;
                uncorr_count <= '0;
            end else if (advance && (scrub_addr != LAST_ADDR)) begin
                scrub_addr <= scrub_addr + 1'b1;
            end
            if (scrub_port)                   starve <= '0;
            else if (contend && bus.host_gnt) starve <= starve + 1'b1;
            if (inc_corr) corr_word <= dec_word;
            if (inc_corr && (corr_count != {CNT_W{1'b1}}))
                corr_count <= corr_count + 1'b1;
            if (inc_uncorr && (uncorr_count != {CNT_W{1'b1}}))
                uncorr_count <= uncorr_count + 1'b1;
        end
    end

    // Strobes are masked during reset so an aborted pass never reaches the memory.
    always_comb begin
        if (bus.host_gnt) begin
            bus.mem_re   = !bus.host_we && !reset;
            bus.mem_we   = bus.host_we && !reset;
            bus.mem_addr = bus.host_addr;
        end else begin
            bus.mem_re   = (state == ISSUE) && !reset;
            bus.mem_we   = (state == WRITE) && !reset;
            bus.mem_addr = scrub_addr;
        end
        bus.mem_wdata = (state == WRITE) ? corr_word : 13'd0;
        busy          = (state == ISSUE) || (state == CHECK) || (state == WRITE);
        done          = (state == DONE) && !reset;
        err_valid     = ev && !reset;
        err_uncorr    = ev_uncorr && !reset;
        err_addr      = err_valid ? scrub_addr : '0;
        state_dbg     = state;
    end
endmodule

// File: tb/tb_secded_scrubber.sv
// Directed bench for secded_scrubber with a memory model and error/writeback scoreboards.
module tb_secded_scrubber;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int SL     = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    secded_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

    logic              busy, done, err_valid, err_uncorr;
    logic [ADDR_W-1:0] err_addr;
    logic [CNT_W-1:0]  corr_count, uncorr_count;
    logic [2:0]        state_dbg;

    secded_scrubber #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .STARVE_LIMIT(SL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bus          (bus.master),
        .busy         (busy),
        .done         (done),
        .err_valid    (err_valid),
        .err_uncorr   (err_uncorr),
        .err_addr     (err_addr),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count),
        .state_dbg    (state_dbg)
    );

    // Memory model: one-cycle read latency, host write data muxed by host_gnt.
    logic [12:0]       mem [DEPTH];
    logic              ld_en   = 1'b0;
    logic [1:0]        ld_addr = 2'd0;
    logic [12:0]       ld_data = 13'd0;
    logic [12:0]       host_wdata = 13'd0;

    always @(posedge clock) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.mem_we) mem[bus.mem_addr[1:0]] <= bus.host_gnt ? host_wdata : bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[1:0]];
    end

    int checks = 0;
    int errors = 0;
    int scrub_writes = 0;
    logic [8:0]  exp_err_q[$];
    logic [20:0] exp_wr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop an expectation whenever the DUT reports an error or issues a scrub write.
    always @(negedge clock) begin
        if (err_valid) begin
            if (exp_err_q.size() == 0) check("unexpected_err", 32'({err_uncorr, err_addr}), 32'h1ff);
            else check("err_report", 32'({err_uncorr, err_addr}), 32'(exp_err_q.pop_front()));
        end
        if (bus.mem_we && !bus.host_gnt) begin
            scrub_writes++;
            if (exp_wr_q.size() == 0) check("unexpected_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'h1fffff);
            else check("scrub_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_wr_q.pop_front()));
        end
    end

    task automatic load(input logic [1:0] a, input logic [12:0] d);
        @(posedge clock); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    task automatic fill(input logic [12:0] d);
        for (int a = 0; a < DEPTH; a++) load(2'(a), d);
    endtask

    task automatic start_pass();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 100);
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_err(input string tag, input logic [ADDR_W-1:0] a);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(err_valid && err_addr == a) && n < 100);
        check(tag, 32'(err_valid && err_addr == a), 32'd1);
    endtask

    initial begin
        int done_pulses;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'({err_valid, err_uncorr, err_addr}), 32'd0);
        check("rst_mem", 32'({bus.mem_re, bus.mem_we, bus.mem_wdata}), 32'd0);
        check("rst_cnt", 32'({corr_count, uncorr_count}), 32'd0);
        fill(13'h0000);
        @(posedge clock); #1 reset = 1'b0;

        // Clean pass: busy cycles 1-8, done in cycle 9
        @(posedge clock); #1 start = 1'b1;
        @(negedge clock);
        check("t1_busy_c0", 32'(busy), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1 start = 1'b0;
            @(negedge clock);
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 8));
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 9));
        end
        check("t1_counts", 32'({corr_count, uncorr_count}), 32'd0);
        check("t1_no_writes", 32'(scrub_writes), 32'd0);

        // Correctable at 2 and double error at 1
        load(2'd1, 13'h0006);
        load(2'd2, 13'h0020);
        exp_err_q.push_back({1'b1, 8'd1});
        exp_err_q.push_back({1'b0, 8'd2});
        exp_wr_q.push_back({8'd2, 13'h0000});
        start_pass();
        wait_err("t2_err2_seen", 8'd2);
        check("t2_err2_uncorr", 32'(err_uncorr), 32'd0);
        @(negedge clock);
        check("t2_wb_we", 32'(bus.mem_we), 32'd1);
        check("t2_wb_addr", 32'(bus.mem_addr), 32'd2);
        check("t2_wb_data", 32'(bus.mem_wdata), 32'h0000);
        wait_done("t2_done");
        check("t2_corr", 32'(corr_count), 32'd1);
        check("t2_uncorr", 32'(uncorr_count), 32'd1);
        check("t2_mem1", 32'(mem[1]), 32'h0006);
        check("t2_mem2", 32'(mem[2]), 32'h0000);

        // Syndrome 13 with parity mismatch
        load(2'd1, 13'h0112);
        exp_err_q.push_back({1'b1, 8'd1});
        start_pass();
        wait_done("t3_done");
        check("t3_corr", 32'(corr_count), 32'd0);
        check("t3_uncorr", 32'(uncorr_count), 32'd1);
        check("t3_mem1", 32'(mem[1]), 32'h0112);
        load(2'd1, 13'h0000);

        // Starvation guard: 8 granted host cycles, one forced cycle, then host again
        @(posedge clock); #1;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'd3; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1 start = 1'b0;
            @(negedge clock);
            check($sformatf("t4_gnt_c%0d", c), 32'(bus.host_gnt), 32'(c != 9));
            if (c == 9) begin
                check("t4_forced_re", 32'(bus.mem_re), 32'd1);
                check("t4_forced_addr", 32'(bus.mem_addr), 32'd0);
            end
        end
        @(posedge clock); #1 bus.host_req = 1'b0;
        wait_done("t4_done");
        check("t4_counts", 32'({corr_count, uncorr_count}), 32'd0);

        // Host write to the pending writeback address cancels the writeback
        load(2'd3, 13'h0020);
        exp_err_q.push_back({1'b0, 8'd3});
        start_pass();
        wait_err("t5_err3_seen", 8'd3);
        @(posedge clock); #1;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'd3; host_wdata = 13'h0aaa;
        @(negedge clock);
        check("t5_state_write", 32'(state_dbg), 32'd3);
        check("t5_host_gnt", 32'(bus.host_gnt), 32'd1);
        @(posedge clock); #1;
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        wait_done("t5_done");
        check("t5_corr", 32'(corr_count), 32'd1);
        check("t5_mem3", 32'(mem[3]), 32'h0aaa);
        load(2'd3, 13'h0000);

        // Reset during WRITE aborts with no write
        load(2'd0, 13'h0001);
        exp_err_q.push_back({1'b0, 8'd0});
        start_pass();
        wait_err("t6_err0_seen", 8'd0);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("t6_we_masked", 32'(bus.mem_we), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("t6_state", 32'(state_dbg), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_we", 32'(bus.mem_we), 32'd0);
        check("t6_counts", 32'({corr_count, uncorr_count}), 32'd0);
        check("t6_mem0", 32'(mem[0]), 32'h0001);
        @(posedge clock); #1 reset = 1'b0;
        load(2'd0, 13'h0000);

        // Start while busy is ignored
        done_pulses = 0;
        @(posedge clock); #1 start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clock); #1 start = (c == 3);
            @(negedge clock);
            if (done) done_pulses++;
            check($sformatf("t7_done_c%0d", c), 32'(done), 32'(c == 9));
        end
        check("t7_done_pulses", 32'(done_pulses), 32'd1);

        // Counter saturation: four corrections into a 2-bit counter
        fill(13'h0020);
        for (int a = 0; a < DEPTH; a++) begin
            exp_err_q.push_back({1'b0, 8'(a)});
            exp_wr_q.push_back({8'(a), 13'h0000});
        end
        start_pass();
        wait_done("t8_done");
        check("t8_corr_sat", 32'(corr_count), 32'd3);
        check("t8_uncorr", 32'(uncorr_count), 32'd0);
        for (int a = 0; a < DEPTH; a++) check($sformatf("t8_mem%0d", a), 32'(mem[a]), 32'h0000);

        check("err_q_empty", 32'(exp_err_q.size()), 32'd0);
        check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
